// File: rtl/serial_incrementer.sv
// Bit-serial incrementer: adds a 1-bit carry-in to an operand one bit per clock.
// Define SERIAL_INC_EARLY_EXIT_EN to finish as soon as the carry dies out.
module serial_incrementer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] result_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic op_bit;
  logic sum_d;
  logic carry_d;
  logic finish_d;

  // Half adder on the current bit; the addend is always zero.
  always_comb begin
    op_bit  = op_q[idx_q];
    sum_d   = op_bit ^ carry_q;
    carry_d = op_bit & carry_q;
`ifdef SERIAL_INC_EARLY_EXIT_EN
    // Once the carry is gone the remaining bits already equal the operand.
    finish_d = !carry_d || (idx_q == LastIdx);
`else
    finish_d = (idx_q == LastIdx);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= operand;
            result_q <= operand;
            carry_q  <= cin;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          result_q[idx_q] <= sum_d;
          carry_q         <= carry_d;
          idx_q           <= idx_q + IdxW'(1);
          if (finish_d) begin
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_incrementer.sv
// Self-checking bench for serial_incrementer against an arithmetic reference model.
// Honours SERIAL_INC_EARLY_EXIT_EN for the expected run length.
module tb_serial_incrementer;

  localparam int unsigned W = 8;
  localparam int Bound = 3 * W + 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] operand;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int checks = 0;
  int passes = 0;

  serial_incrementer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .operand(operand),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain (W+1)-bit addition.
  function automatic logic [W:0] model_sum(input logic [W-1:0] op, input logic ci);
    return {1'b0, op} + {{W{1'b0}}, ci};
  endfunction

  // Expected number of RUN cycles.
  function automatic int model_runs(input logic [W-1:0] op, input logic ci);
`ifdef SERIAL_INC_EARLY_EXIT_EN
    int n = 0;
    if (!ci) return 1;
    while (n < int'(W) && op[n]) n++;
    return (n + 1 < int'(W)) ? n + 1 : int'(W);
`else
    return int'(W);
`endif
  endfunction

  // Starts one operation, scrambles the inputs after acceptance, waits for done.
  task automatic run_op(input logic [W-1:0] op, input logic ci, output int cyc);
    operand = op;
    cin     = ci;
    start   = 1'b1;
    step();
    start   = 1'b0;
    operand = W'($urandom);
    cin     = 1'($urandom);
    cyc = 0;
    while (!done && cyc < Bound) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    operand = 8'hFF;
    cin   = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, result, cout} !== '0) begin
      $display("FAIL reset_state: got busy=%b done=%b result=%h cout=%b, want all zero",
               busy, done, result, cout);
    end else passes++;
    rst   = 1'b0;
    start = 1'b0;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end else passes++;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] op, input logic ci);
    int          cyc;
    logic [W:0]  exp;
    exp = model_sum(op, ci);
    run_op(op, ci, cyc);
    checks++;
    if (cyc !== model_runs(op, ci)) begin
      $display("FAIL %s_latency op=%h cin=%b: done after %0d run cycles, want %0d",
               name, op, ci, cyc, model_runs(op, ci));
    end else passes++;
    checks++;
    if ({cout, result} !== exp) begin
      $display("FAIL %s_result op=%h cin=%b: got cout=%b result=%h, want cout=%b result=%h",
               name, op, ci, cout, result, exp[W], exp[W-1:0]);
    end else passes++;
    step();
    step();
    checks++;
    if ({busy, done, cout, result} !== {2'b00, exp}) begin
      $display("FAIL %s_hold op=%h: got busy=%b done=%b cout=%b result=%h, want 0 0 %b %h",
               name, op, busy, done, cout, result, exp[W], exp[W-1:0]);
    end else passes++;
  endtask

  task automatic test_directed();
    check_op("dir_00", 8'h00, 1'b1);
    check_op("dir_37", 8'h37, 1'b1);
    check_op("dir_a5", 8'hA5, 1'b0);
    check_op("dir_ff", 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] op;
    for (int i = 0; i < 24; i++) begin
      op = W'($urandom);
      // Bias toward long runs of trailing ones to exercise carry propagation.
      if ($urandom_range(0, 2) == 0) op = op | W'((32'd1 << $urandom_range(0, W)) - 1);
      check_op("rand", op, 1'($urandom));
    end
  endtask

  task automatic test_start_ignored();
    int cyc = 0;
    int pulses = 0;
    operand = 8'h3B;
    cin     = 1'b1;
    start   = 1'b1;
    step();
    operand = 8'hC0;
    cin     = 1'b0;
    while (!done && cyc < Bound) begin
      step();
      cyc++;
    end
    checks++;
    if (result !== 8'h3C || cout !== 1'b0) begin
      $display("FAIL ignore_start_result: got result=%h cout=%b, want 3c 0", result, cout);
    end else passes++;
    start = 1'b0;
    for (int i = 0; i < 2 * int'(W); i++) begin
      step();
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b0) begin
      $display("FAIL ignore_start_queue: got %0d extra done pulses busy=%b, want 0 0",
               pulses, busy);
    end else passes++;
  endtask

  task automatic test_reset_midrun();
    int pulses = 0;
    operand = 8'hFF;
    cin     = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    checks++;
    if ({busy, done, result, cout} !== '0) begin
      $display("FAIL midrun_reset: got busy=%b done=%b result=%h cout=%b, want all zero",
               busy, done, result, cout);
    end else passes++;
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2 * int'(W); i++) begin
      step();
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      $display("FAIL midrun_no_done: got %0d busy/done cycles after reset, want 0", pulses);
    end else passes++;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int pulses = 0;
    operand = 8'h10;
    cin     = 1'b1;
    start   = 1'b1;
    step();
    operand = 8'h7F;
    while (!done && cyc < Bound) begin
      step();
      cyc++;
    end
    if (done) pulses++;
    checks++;
    if (result !== 8'h11 || cout !== 1'b0) begin
      $display("FAIL b2b_first: got result=%h cout=%b, want 11 0", result, cout);
    end else passes++;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL b2b_gap: got busy=%b done=%b, want 0 0", busy, done);
    end else passes++;
    step();
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL b2b_accept: got busy=%b one cycle after done, want 1", busy);
    end else passes++;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < Bound) begin
      step();
      cyc++;
    end
    if (done) pulses++;
    checks++;
    if (cyc !== model_runs(8'h7F, 1'b1) || result !== 8'h80 || cout !== 1'b0) begin
      $display("FAIL b2b_second: got runs=%0d result=%h cout=%b, want %0d 80 0",
               cyc, result, cout, model_runs(8'h7F, 1'b1));
    end else passes++;
    for (int i = 0; i < int'(W); i++) begin
      step();
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 2) begin
      $display("FAIL b2b_pulses: got %0d done pulses, want 2", pulses);
    end else passes++;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    operand = '0;
    cin     = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_incrementer.md
SERIAL_INCREMENTER -- requirements
Module: serial_incrementer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port operand  input  WIDTH  minuend-style input value, captured when start is accepted.
REQ-006 The block SHALL have port cin  input  1  carry-in (increment amount 0 or 1), captured with operand.
REQ-007 The block SHALL have port busy  output  1  high while in RUN or DONE.
REQ-008 The block SHALL have port done  output  1  single-cycle completion pulse.
REQ-009 The block SHALL have port result  output  WIDTH  operand + cin, modulo 2^WIDTH.
REQ-010 The block SHALL have port cout  output  1  final carry-out, set only on wrap-around.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL load the operand register, result register := operand, carry := cin, bit index := 0, and go to RUN.
REQ-013 Each RUN cycle SHALL process bit i via a half-adder (addend 0): result[i] := op[i] XOR carry; carry := op[i] AND carry; i := i+1.
REQ-014 Without the early-exit feature, RUN SHALL last exactly WIDTH cycles, then DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 If start is sampled at edge t, done SHALL be observed high at edge t+R+1, where R is the number of RUN cycles.
REQ-017 cout SHALL equal the final carry and update with result on entry to DONE.
REQ-018 result and cout SHALL hold their values from DONE until the next accepted start.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing.
REQ-020 A start held continuously SHALL be accepted at the first IDLE edge after DONE (one idle cycle between operations).
REQ-021 operand and cin changes after acceptance SHALL NOT affect the operation in progress.
REQ-022 On all-ones operand with cin=1, result SHALL be 0 and cout SHALL be 1.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE with busy=0, done=0, result=0, cout=0, carry=0, index=0, regardless of state.
REQ-024 rst SHALL dominate start in the same cycle.
REQ-025 An operation interrupted by reset SHALL be discarded; no done pulse is produced.

Configuration
REQ-026 Macro SERIAL_INC_EARLY_EXIT_EN SHALL control early termination.
REQ-027 With SERIAL_INC_EARLY_EXIT_EN defined, a RUN cycle whose next carry is 0, or which processes bit WIDTH-1, SHALL transition to DONE. Untouched upper bits already equal operand. R = 1 for cin=0, R = min(trailing_ones(operand)+1, WIDTH) for cin=1.
REQ-028 Without SERIAL_INC_EARLY_EXIT_EN, R SHALL be WIDTH for every operation. Result and cout SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-029 start, operand=0x00, cin=1 -> result=0x01, cout=0; done at edge t+9 (no EN) or t+2 (EN).
REQ-030 operand=0xFF, cin=1 -> result=0x00, cout=1; done at edge t+9 in both builds.
REQ-031 operand=0x37, cin=1 -> result=0x38, cout=0; done at edge t+9 (no EN) or t+5 (EN).
REQ-032 operand=0xA5, cin=0 -> result=0xA5, cout=0; done at edge t+9 (no EN) or t+2 (EN).
REQ-033 rst=1 three cycles into RUN, with start pulsed during RUN -> next edge shows IDLE, busy=0, result=0, cout=0; no done pulse follows.
REQ-034 start held high, operands 0x10 then 0x7F, cin=1 -> results 0x11 then 0x80, each with exactly one done pulse; the second operation is accepted one cycle after the first done.
